pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: load-use stalls, fetch-wait bubbles and branch redirects.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined; otherwise they read as zero.
module pipe_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic [31:0]      redir_pc,
  output logic             fiid_we,
  output logic             fiid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FETCH_WAIT = 2'd1,
    REDIR_WAIT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] redir_r;
  logic        latch_en_s;
  logic        lu_s;

  // Load-use hazard: a load in EX writes a nonzero register that ID reads.
  assign lu_s = ex_mem_read && (ex_rd != {REG_W{1'b0}}) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  // State register and latched redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      redir_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (latch_en_s) begin
        redir_r <= ex_target;
      end else begin
        redir_r <= redir_r;
      end
    end
  end

  // Next-state and control outputs; reset forces the safe bubble/flush pattern.
  always_comb begin
    state_nxt_s = state_r;
    latch_en_s  = 1'b0;
    pc_we       = 1'b0;
    pc_redirect = 1'b0;
    redir_pc    = redir_r;
    fiid_we     = 1'b0;
    fiid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      state_nxt_s = RUN;
      redir_pc    = 32'd0;
      fiid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_r)
        RUN, FETCH_WAIT: begin
          if (ex_redirect) begin
            redir_pc    = ex_target;
            fiid_we     = 1'b1;
            fiid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (imem_ready) begin
              pc_we       = 1'b1;
              pc_redirect = 1'b1;
              state_nxt_s = RUN;
            end else begin
              latch_en_s  = 1'b1;
              state_nxt_s = REDIR_WAIT;
            end
          end else if (lu_s) begin
            // Hold PC and FI_ID; a still-pending fetch keeps us waiting.
            idex_bubble = 1'b1;
            if ((state_r == FETCH_WAIT) && !imem_ready) begin
              state_nxt_s = FETCH_WAIT;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (!imem_ready) begin
            fiid_we     = 1'b1;
            fiid_flush  = 1'b1;
            state_nxt_s = FETCH_WAIT;
          end else begin
            pc_we       = 1'b1;
            fiid_we     = 1'b1;
            state_nxt_s = RUN;
          end
        end
        REDIR_WAIT: begin
          fiid_we     = 1'b1;
          fiid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (ex_redirect) begin
            // Newest target wins; wait one more cycle so the issued PC is the latched one.
            latch_en_s  = 1'b1;
            state_nxt_s = REDIR_WAIT;
          end else if (imem_ready) begin
            pc_we       = 1'b1;
            pc_redirect = 1'b1;
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = REDIR_WAIT;
          end
        end
        default: begin
          fiid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nxt_s = RUN;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_r;
  logic [CNT_W-1:0] flush_r;
  logic             redir_flush_s;

  // Every flush in REDIR_WAIT, and every flush alongside a redirect, is redirect-caused.
  assign redir_flush_s = fiid_flush && ((state_r == REDIR_WAIT) || ex_redirect);

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_r <= {CNT_W{1'b0}};
      flush_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_we && (stall_r != {CNT_W{1'b1}})) begin
        stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_r <= stall_r;
      end
      if (redir_flush_s && (flush_r != {CNT_W{1'b1}})) begin
        flush_r <= flush_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_r <= flush_r;
      end
    end
  end

  assign stall_cycles = stall_r;
  assign flush_count  = flush_r;
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl plus hand-written redirect/reset/counter sequences.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_STATS_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 32;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                imem_ready;
  logic [4:0]          id_rs, id_rt, ex_rd;
  logic                id_use_rs, id_use_rt, ex_mem_read, ex_redirect;
  logic [31:0]         ex_target;
  logic                pc_we, pc_redirect, fiid_we, fiid_flush, idex_bubble;
  logic [31:0]         redir_pc;
  logic [TB_CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  pipe_ctrl #(.REG_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .pc_we(pc_we), .pc_redirect(pc_redirect), .redir_pc(redir_pc),
    .fiid_we(fiid_we), .fiid_flush(fiid_flush), .idex_bubble(idex_bubble),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [4:0]  rs, rt;
    logic        urs, urt, mr;
    logic [4:0]  rd;
    logic        redir;
    logic [31:0] tgt;
    logic        e_pcwe, e_pcr;
    logic [31:0] e_rpc;
    logic        e_fwe, e_ffl, e_bub;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(input logic ready, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic mr, input logic [4:0] rd,
                              input logic redir, input logic [31:0] tgt,
                              input logic e_pcwe, input logic e_pcr, input logic [31:0] e_rpc,
                              input logic e_fwe, input logic e_ffl, input logic e_bub);
    vec_t v;
    v.ready = ready; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr; v.rd = rd;
    v.redir = redir; v.tgt = tgt; v.e_pcwe = e_pcwe; v.e_pcr = e_pcr; v.e_rpc = e_rpc;
    v.e_fwe = e_fwe; v.e_ffl = e_ffl; v.e_bub = e_bub;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_pcwe, input logic e_pcr,
                          input logic [31:0] e_rpc, input logic e_fwe, input logic e_ffl,
                          input logic e_bub);
    chk({tag, ".pc_we"}, {31'd0, pc_we}, {31'd0, e_pcwe});
    chk({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, e_pcr});
    chk({tag, ".redir_pc"}, redir_pc, e_rpc);
    chk({tag, ".fiid_we"}, {31'd0, fiid_we}, {31'd0, e_fwe});
    chk({tag, ".fiid_flush"}, {31'd0, fiid_flush}, {31'd0, e_ffl});
    chk({tag, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, e_bub});
  endtask

  task automatic drive(input logic ready, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr, input logic [4:0] rd,
                       input logic redir, input logic [31:0] tgt);
    imem_ready = ready; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_mem_read = mr; ex_rd = rd; ex_redirect = redir; ex_target = tgt;
  endtask

  // Advance to just after the next rising edge, then apply a plain ready/no-hazard input set.
  task automatic step_idle(input logic ready);
    @(posedge clk); #1;
    drive(ready, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 32'd0);
    //        rdy rs    rt    urs  urt  mr   rd    redir tgt         pcwe pcr  rpc          fwe  ffl  bub
    vt[0]  = mk(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0);
    vt[1]  = mk(1, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 32'h0,        0, 0, 32'h0,   0, 0, 1);
    vt[2]  = mk(1, 5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0);
    vt[3]  = mk(1, 5'd0, 5'd7, 0, 1, 1, 5'd7, 0, 32'h0,        0, 0, 32'h0,   0, 0, 1);
    vt[4]  = mk(1, 5'd0, 5'd7, 0, 0, 1, 5'd7, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0);
    vt[5]  = mk(1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0);
    vt[6]  = mk(1, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 32'h40,       1, 1, 32'h40,  1, 1, 1);
    vt[7]  = mk(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        0, 0, 32'h0,   1, 1, 0);
    vt[8]  = mk(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        0, 0, 32'h0,   1, 1, 0);
    vt[9]  = mk(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0);
    vt[10] = mk(0, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 32'h0,        0, 0, 32'h0,   0, 0, 1);
    vt[11] = mk(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0);
    vt[12] = mk(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 32'h100,      0, 0, 32'h100, 1, 1, 1);
    vt[13] = mk(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        0, 0, 32'h100, 1, 1, 1);
    vt[14] = mk(0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 32'h200,      0, 0, 32'h100, 1, 1, 1);
    vt[15] = mk(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        1, 1, 32'h200, 1, 1, 1);
    vt[16] = mk(1, 5'd1, 5'd2, 1, 1, 0, 5'd3, 0, 32'h0,        1, 0, 32'h200, 1, 0, 0);

    #12;
    chk_outs("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset.flush_count", 32'(flush_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      drive(vt[i].ready, vt[i].rs, vt[i].rt, vt[i].urs, vt[i].urt, vt[i].mr, vt[i].rd,
            vt[i].redir, vt[i].tgt);
      #3;
      chk_outs($sformatf("vec%0d", i), vt[i].e_pcwe, vt[i].e_pcr, vt[i].e_rpc,
               vt[i].e_fwe, vt[i].e_ffl, vt[i].e_bub);
    end

    // Fetch miss, redirect during the miss, release after three missing cycles.
    step_idle(1'b0); #3;
    chk_outs("seq_fw_c1", 1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 32'h80); #3;
    chk_outs("seq_fw_c2", 1'b0, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1);
    step_idle(1'b0); #3;
    chk_outs("seq_fw_c3", 1'b0, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1);
    step_idle(1'b1); #3;
    chk_outs("seq_fw_rel", 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
    step_idle(1'b1); #3;
    chk_outs("seq_fw_run", 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0);

    // Reset while a redirect is pending must drop it.
    @(posedge clk); #1;
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 32'h300); #3;
    chk_outs("seq_rst_enter", 1'b0, 1'b0, 32'h300, 1'b1, 1'b1, 1'b1);
    step_idle(1'b0); #1;
    rst = 1'b0; #1;
    chk_outs("seq_rst_now", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("seq_rst.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("seq_rst.flush_count", 32'(flush_count), 32'd0);
    @(negedge clk);
    imem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk_outs("seq_rst_after", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step_idle(1'b1); #3;
    chk_outs("seq_rst_after2", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Twenty load-use stall cycles from a fresh reset.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 32'd0);
    for (int c = 0; c < 20; c++) @(posedge clk);
    #1;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 32'd0);
    #3;
`ifdef PIPE_CTRL_STATS_EN
    chk("stats.stall_sat", 32'(stall_cycles), 32'd15);
`else
    chk("stats.stall_off", 32'(stall_cycles), 32'd0);
`endif
    chk("stats.flush_none", 32'(flush_count), 32'd0);
    step_idle(1'b1); #3;
`ifdef PIPE_CTRL_STATS_EN
    chk("stats.stall_held", 32'(stall_cycles), 32'd15);
`else
    chk("stats.stall_held_off", 32'(stall_cycles), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
